ro_freq_counter: RTL and testbench
==================================

# ro_freq_counter

Gated edge counter that sits directly downstream of the ring oscillator. It measures the oscillator frequency in the `clk` domain. It synchronizes the free-running, asynchronous oscillator output, counts its rising edges over a programmable window of `clk` cycles, and holds the result until the next measurement completes. The top-level wrapper starts measurements and muxes the result onto the dedicated outputs.

## Interface
Parameters:
- `CNT_W`, 16: width of edge count result.
- `GATE_W`, 16: width of gate-length operand, in `clk` cycles.

Ports:
- `clk`  input  1  system clock; one clock domain.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ro_in`  input  1  ring oscillator output; asynchronous to `clk`.
- `start`  input  1  single-cycle request to begin a measurement; sampled only in IDLE.
- `gate_len`  input  GATE_W  window length in `clk` cycles; latched on accepted `start`.
- `busy`  output  1  high while a measurement is in progress (GATE and DONE).
- `done`  output  1  one-cycle pulse when `count` and `overflow` update.
- `count`  output  CNT_W  rising edges counted in the last window; held between measurements.
- `overflow`  output  1  last measurement saturated `count`; held with `count`.

## Operation
- Synchronizer: 2-flop synchronizer on `ro_in`, then a third flop (`prev`). A rising edge is detected when sync=1 and prev=0. All three flops reset to 0.
- Valid frequency range: `ro_in` below `clk`/4. Faster inputs alias; upstream provides a divided tap.
- FSM states:
  - IDLE: `busy`=0. `start`=1 latches `gate_len` into the remaining-cycle counter `rem`. Goes to DONE if `gate_len`==0, else to GATE. The working edge accumulator clears to 0.
  - GATE: each cycle, add 1 to the accumulator if an edge is detected that cycle, then decrement `rem`. When `rem`==1 in this cycle (last gate cycle), still count that cycle's edge, then go to DONE.
  - DONE: copy the accumulator to `count` and its saturation flag to `overflow`. Pulse `done`. Return to IDLE.
- Saturation: the accumulator stops at 2^CNT_W−1 and does not wrap. It sets the saturation flag on any edge arriving while already at max.
- `start` in GATE or DONE is ignored; no queuing.
- `gate_len` changes after acceptance have no effect.
- Reset mid-operation: immediate return to IDLE. `count`=0, `overflow`=0, `done`=0, `busy`=0, accumulator and `rem` = 0. The aborted result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, `overflow`=0.
- `start` accepted at rising edge k (state IDLE). GATE occupies cycles k+1 … k+`gate_len`. DONE is cycle k+`gate_len`+1, with `done`=1 and new `count`/`overflow` visible that cycle. IDLE resumes at k+`gate_len`+2.
- `gate_len`=0: DONE at cycle k+1, `count`=0, `overflow`=0.
- Edge-detect latency: 2–3 `clk` cycles from a pin transition. The window is therefore shifted by that amount relative to pin time, and the result has ±1 count uncertainty.
- After `rst_n` deassertion, allow 3 cycles before `start`. If `ro_in` is high at release, a 0→1 synchronizer transition produces one spurious edge that must fall outside the window.
- Back-to-back: the earliest next `start` is in the IDLE cycle k+`gate_len`+2.

## Structure
- Shared package `ro_meas_pkg`:
  - state enum typedef (`IDLE`, `GATE`, `DONE`);
  - synchronizer depth localparam (2).
- Sub-module `sync_2ff`: a generic single-bit 2-flop synchronizer with async active-low reset to 0. It is reused for any other asynchronous pad inputs.
- The counter, FSM and result registers stay in `ro_freq_counter`.

## Test plan
- Period measurement: `ro_in` square wave, period 8 `clk` cycles; `gate_len`=80, `start` pulse → `done` at start+81, `count`∈{9,10,11}, `overflow`=0.
- Static input: `ro_in` held 0 after reset; `gate_len`=50 → `count`=0, `overflow`=0, `busy` high for exactly 51 cycles.
- Saturation: `CNT_W`=4, `ro_in` period 4, `gate_len`=100 → `count`=15, `overflow`=1. The next run with `ro_in`=0 → `count`=0, `overflow`=0.
- Zero gate: `gate_len`=0, `start` → `done` the next cycle, `count`=0, `busy` high for 1 cycle.
- Ignored start: second `start` pulse with `gate_len`=5 mid-GATE of a `gate_len`=40 run → exactly one `done`, at start1+41. `count` reflects the 40-cycle window.
- Reset abort: assert `rst_n`=0 at cycle 20 of a 60-cycle window → all outputs 0 asynchronously, no `done`. A new measurement after release completes normally.

Source files
------------

// File: rtl/ro_meas_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ro_meas_pkg : shared types and constants for oscillator measurement |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } meas_state_e;

    localparam int SYNC_STAGES = 2;

endpackage : ro_meas_pkg
`default_nettype wire

// File: rtl/ro_freq_counter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ro_freq_counter_if : measurement request / result bus              |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface ro_freq_counter_if #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
);
    logic              start;
    logic [GATE_W-1:0] gate_len;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output start, gate_len,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, gate_len,
        output busy, done, count, overflow
    );
endinterface : ro_freq_counter_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_2ff : single-bit flop synchronizer for asynchronous pad inputs |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sync_2ff
    import ro_meas_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d_i,
    output logic      q_o
);
    logic [SYNC_STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[SYNC_STAGES-1];
endmodule : sync_2ff
`default_nettype wire

// File: rtl/ro_freq_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ro_freq_counter : gated rising-edge counter for a ring oscillator   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         ro_in,
    ro_freq_counter_if.slave  bus
);
    logic              ro_sync;
    logic              prev_q;
    logic              edge_det;
    meas_state_e       state_q;
    logic [GATE_W-1:0] rem_q;
    logic [CNT_W-1:0]  acc_q;
    logic [CNT_W-1:0]  acc_d;
    logic              sat_q;
    logic              sat_d;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic              done_q;
    logic              busy_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ro_in),
        .q_o   (ro_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= ro_sync;
        end
    end

    assign edge_det = ro_sync & ~prev_q;

    // Accumulator saturates at all-ones; further edges only raise the flag.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (edge_det) begin
            if (&acc_q) begin
                sat_d = 1'b1;
            end else begin
                acc_d = acc_q + CNT_W'(1);
            end
        end
    end

    // Result is loaded on the transition into DONE so it is visible with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        rem_q  <= bus.gate_len;
                        acc_q  <= '0;
                        sat_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.gate_len == '0) begin
                            state_q <= DONE;
                            count_q <= '0;
                            ovf_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= GATE;
                        end
                    end
                end
                GATE: begin
                    acc_q <= acc_d;
                    sat_q <= sat_d;
                    rem_q <= rem_q - GATE_W'(1);
                    if (rem_q == GATE_W'(1)) begin
                        state_q <= DONE;
                        count_q <= acc_d;
                        ovf_q   <= sat_d;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule : ro_freq_counter
`default_nettype wire

// File: tb/tb_ro_freq_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ro_freq_counter : self-checking bench, 16-bit and 4-bit counters |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_ro_freq_counter;

    logic clk;
    logic rst_n;
    logic ro_a;
    logic ro_b;

    int total;
    int bad;
    int cyc_cnt;

    bit hist_a [0:65535];
    bit hist_b [0:65535];

    int mode_a, half_a, ph_a;
    int mode_b, half_b, ph_b;

    ro_freq_counter_if #(.CNT_W(16), .GATE_W(16)) ifa ();
    ro_freq_counter_if #(.CNT_W(4),  .GATE_W(16)) ifb ();

    ro_freq_counter #(.CNT_W(16), .GATE_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ro_in (ro_a),
        .bus   (ifa.slave)
    );

    ro_freq_counter #(.CNT_W(4), .GATE_W(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ro_in (ro_b),
        .bus   (ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pin value as seen at each rising clock edge, indexed by edge number.
    always @(posedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        hist_a[cyc_cnt] = ro_a;
        hist_b[cyc_cnt] = ro_b;
    end

    // Oscillator models: 0 = static, 1 = square wave, 2 = random toggling.
    always @(negedge clk) begin
        if (mode_a == 1) begin
            if (ph_a >= half_a - 1) begin ro_a = ~ro_a; ph_a = 0; end
            else ph_a = ph_a + 1;
        end else if (mode_a == 2) begin
            if ($urandom_range(0, 2) == 0) ro_a = ~ro_a;
        end
        if (mode_b == 1) begin
            if (ph_b >= half_b - 1) begin ro_b = ~ro_b; ph_b = 0; end
            else ph_b = ph_b + 1;
        end else if (mode_b == 2) begin
            if ($urandom_range(0, 2) == 0) ro_b = ~ro_b;
        end
    end

    // Reference: a pin rise seen between edges m-3 and m-2 lands in the
    // accumulator at edge m (two sync stages plus the edge detector).
    function automatic void ref_count(input int d, input int k, input int len,
                                      input int w, output int cnt, output bit ovf);
        int maxv;
        bit cur, prv;
        maxv = (1 << w) - 1;
        cnt = 0;
        ovf = 1'b0;
        for (int m = k + 1; m <= k + len; m++) begin
            cur = (d == 0) ? hist_a[m-2] : hist_b[m-2];
            prv = (d == 0) ? hist_a[m-3] : hist_b[m-3];
            if (cur && !prv) begin
                if (cnt == maxv) ovf = 1'b1;
                else cnt = cnt + 1;
            end
        end
    endfunction

    task automatic drive(input int d, input logic s, input int g);
        if (d == 0) begin ifa.start = s; ifa.gate_len = 16'(g); end
        else begin ifb.start = s; ifb.gate_len = 16'(g); end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; start is accepted at the following rising edge k.
    task automatic measure(input int d, input int len, input int xs_at, input int xs_len,
                           output int k, output int done_cyc, output int ndone,
                           output int nbusy, output int cnt, output bit ovf,
                           output bit timeout);
        logic b, dn, o;
        int c;
        ndone = 0; nbusy = 0; done_cyc = -1; cnt = 0; ovf = 1'b0; timeout = 1'b1;
        drive(d, 1'b1, len);
        k = cyc_cnt + 1;
        for (int i = 0; i < len + 20; i++) begin
            @(negedge clk);
            if (i == xs_at) drive(d, 1'b1, xs_len);
            else drive(d, 1'b0, int'($urandom_range(0, 65535)));
            if (d == 0) begin b = ifa.busy; dn = ifa.done; c = int'(ifa.count); o = ifa.overflow; end
            else begin b = ifb.busy; dn = ifb.done; c = int'(ifb.count); o = ifb.overflow; end
            if (b) nbusy++;
            if (dn) begin ndone++; done_cyc = cyc_cnt; cnt = c; ovf = o; end
            if (done_cyc >= 0 && cyc_cnt == done_cyc + 1) begin timeout = 1'b0; break; end
        end
        drive(d, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({ifa.busy, ifa.done, ifa.count, ifa.overflow} !== 19'd0) begin
            bad++; $display("FAIL reset_a got=%b exp=0", {ifa.busy, ifa.done, ifa.count, ifa.overflow});
        end
        total++;
        if ({ifb.busy, ifb.done, ifb.count, ifb.overflow} !== 7'd0) begin
            bad++; $display("FAIL reset_b got=%b exp=0", {ifb.busy, ifb.done, ifb.count, ifb.overflow});
        end
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(5);
    endtask

    task automatic test_period();
        int k, dc, nd, nb, cnt, ec; bit ovf, eo, to;
        mode_a = 1; half_a = 4; ph_a = 0;
        wait_neg(3);
        measure(0, 80, -1, 0, k, dc, nd, nb, cnt, ovf, to);
        ref_count(0, k, 80, 16, ec, eo);
        total++;
        if (to || dc !== k + 80) begin bad++; $display("FAIL period_done_time got=%0d exp=%0d", dc, k + 80); end
        total++;
        if (cnt < 9 || cnt > 11 || cnt !== ec) begin bad++; $display("FAIL period_count got=%0d exp=%0d", cnt, ec); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL period_ovf got=%0d exp=0", ovf); end
    endtask

    task automatic test_static();
        int k, dc, nd, nb, cnt; bit ovf, to;
        mode_a = 0; ro_a = 1'b0;
        wait_neg(5);
        measure(0, 50, -1, 0, k, dc, nd, nb, cnt, ovf, to);
        total++;
        if (to || cnt !== 0 || ovf !== 1'b0) begin bad++; $display("FAIL static_count got=%0d/%0d exp=0/0", cnt, ovf); end
        total++;
        if (nb !== 51) begin bad++; $display("FAIL static_busy got=%0d exp=51", nb); end
    endtask

    task automatic test_saturation();
        int k, dc, nd, nb, cnt, ec; bit ovf, eo, to;
        mode_b = 1; half_b = 2; ph_b = 0;
        wait_neg(3);
        measure(1, 100, -1, 0, k, dc, nd, nb, cnt, ovf, to);
        ref_count(1, k, 100, 4, ec, eo);
        total++;
        if (to || cnt !== 15 || ec !== 15) begin bad++; $display("FAIL sat_count got=%0d exp=15", cnt); end
        total++;
        if (ovf !== 1'b1 || eo !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%0d exp=1", ovf); end
        mode_b = 0; ro_b = 1'b0;
        wait_neg(5);
        measure(1, 100, -1, 0, k, dc, nd, nb, cnt, ovf, to);
        total++;
        if (to || cnt !== 0 || ovf !== 1'b0) begin bad++; $display("FAIL sat_clear got=%0d/%0d exp=0/0", cnt, ovf); end
    endtask

    task automatic test_zero_gate();
        int k, dc, nd, nb, cnt; bit ovf, to;
        mode_a = 1; half_a = 3; ph_a = 0;
        wait_neg(2);
        measure(0, 0, -1, 0, k, dc, nd, nb, cnt, ovf, to);
        total++;
        if (to || dc !== k) begin bad++; $display("FAIL zero_done_time got=%0d exp=%0d", dc, k); end
        total++;
        if (cnt !== 0 || ovf !== 1'b0 || nb !== 1) begin
            bad++; $display("FAIL zero_result got=cnt%0d ovf%0d busy%0d exp=0/0/1", cnt, ovf, nb);
        end
    endtask

    task automatic test_ignored_start();
        int k, dc, nd, nb, cnt, ec, extra; bit ovf, eo, to;
        mode_a = 2;
        wait_neg(2);
        measure(0, 40, 10, 5, k, dc, nd, nb, cnt, ovf, to);
        ref_count(0, k, 40, 16, ec, eo);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifa.done) extra++;
        end
        total++;
        if (to || nd + extra !== 1 || dc !== k + 40) begin
            bad++; $display("FAIL ignored_start got=dones%0d at%0d exp=1 at%0d", nd + extra, dc, k + 40);
        end
        total++;
        if (cnt !== ec || ovf !== eo) begin bad++; $display("FAIL ignored_count got=%0d exp=%0d", cnt, ec); end
    endtask

    task automatic test_back_to_back();
        int k1, k2, dc, nd, nb, cnt, ec, l1, l2; bit ovf, eo, to;
        mode_a = 1; half_a = 3; ph_a = 0;
        wait_neg(3);
        l1 = int'($urandom_range(5, 30));
        l2 = int'($urandom_range(5, 30));
        measure(0, l1, -1, 0, k1, dc, nd, nb, cnt, ovf, to);
        measure(0, l2, -1, 0, k2, dc, nd, nb, cnt, ovf, to);
        ref_count(0, k2, l2, 16, ec, eo);
        total++;
        if (to || k2 !== k1 + l1 + 2 || dc !== k2 + l2) begin
            bad++; $display("FAIL b2b_timing got=done%0d exp=%0d", dc, k1 + l1 + 2 + l2);
        end
        total++;
        if (cnt !== ec || ovf !== eo) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", cnt, ec); end
    endtask

    task automatic test_random();
        int d, len, k, dc, nd, nb, cnt, ec; bit ovf, eo, to;
        for (int it = 0; it < 10; it++) begin
            d = it % 2;
            len = int'($urandom_range(1, 150));
            if (d == 0) begin
                mode_a = int'($urandom_range(1, 2)); half_a = int'($urandom_range(2, 7)); ph_a = 0;
            end else begin
                mode_b = int'($urandom_range(1, 2)); half_b = int'($urandom_range(2, 7)); ph_b = 0;
            end
            wait_neg(int'($urandom_range(1, 4)));
            measure(d, len, -1, 0, k, dc, nd, nb, cnt, ovf, to);
            ref_count(d, k, len, (d == 0) ? 16 : 4, ec, eo);
            total++;
            if (to || dc !== k + len || nb !== len + 1) begin
                bad++; $display("FAIL rand_timing it=%0d got=%0d exp=%0d", it, dc, k + len);
            end
            total++;
            if (cnt !== ec || ovf !== eo) begin
                bad++; $display("FAIL rand_result it=%0d got=%0d/%0d exp=%0d/%0d", it, cnt, ovf, ec, eo);
            end
        end
    endtask

    task automatic test_reset_abort();
        int k, dc, nd, nb, cnt, ec, dn; bit ovf, eo, to;
        mode_a = 1; half_a = 2; ph_a = 0;
        wait_neg(3);
        measure(0, 30, -1, 0, k, dc, nd, nb, cnt, ovf, to);
        ref_count(0, k, 30, 16, ec, eo);
        total++;
        if (to || cnt !== ec || cnt == 0) begin bad++; $display("FAIL abort_pre got=%0d exp=%0d", cnt, ec); end
        drive(0, 1'b1, 60);
        @(negedge clk);
        drive(0, 1'b0, 60);
        wait_neg(19);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ifa.busy, ifa.done, ifa.count, ifa.overflow} !== 19'd0) begin
            bad++; $display("FAIL abort_async got=%b exp=0", {ifa.busy, ifa.done, ifa.count, ifa.overflow});
        end
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifa.done || ifa.busy) dn++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifa.done || ifa.busy) dn++;
        end
        total++;
        if (dn !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
        measure(0, 30, -1, 0, k, dc, nd, nb, cnt, ovf, to);
        ref_count(0, k, 30, 16, ec, eo);
        total++;
        if (to || dc !== k + 30 || cnt !== ec || ovf !== eo) begin
            bad++; $display("FAIL abort_recover got=%0d exp=%0d", cnt, ec);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc_cnt = 0;
        ro_a = 1'b0; ro_b = 1'b0;
        mode_a = 0; half_a = 2; ph_a = 0;
        mode_b = 0; half_b = 2; ph_b = 0;
        ifa.start = 1'b0; ifa.gate_len = '0;
        ifb.start = 1'b0; ifb.gate_len = '0;
        test_reset();
        test_period();
        test_static();
        test_saturation();
        test_zero_gate();
        test_ignored_start();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ro_freq_counter
`default_nettype wire
